// File: rtl/pc_pkg.sv
// Shared types for the program-counter sequencer: the sequencing operation
// enum and the priority decoder that maps raw command bits onto it.
package pc_pkg;

  typedef enum logic [2:0] {
    PC_HOLD,
    PC_INC,
    PC_BRANCH,
    PC_JUMP,
    PC_CALL,
    PC_RET
  } pc_op_t;

  // Highest-priority asserted command wins; everything below it is ignored.
  function automatic pc_op_t pc_decode(
    input logic ret_en,
    input logic call_en,
    input logic hab_jump,
    input logic branch_en,
    input logic controle
  );
    if (ret_en)         return PC_RET;
    else if (call_en)   return PC_CALL;
    else if (hab_jump)  return PC_JUMP;
    else if (branch_en) return PC_BRANCH;
    else if (controle)  return PC_INC;
    else                return PC_HOLD;
  endfunction

endpackage

// File: rtl/pc_ras.sv
// Circular return-address stack. When full, a push overwrites the oldest
// entry and the count saturates at DEPTH; a pop on an empty stack is ignored.
module pc_ras #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           push_data,
  output logic [WIDTH-1:0]           top,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       full,
  output logic                       empty
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [PW-1:0] LAST_IDX = PW'(DEPTH - 1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_ptr;
  logic [CW-1:0]    r_count;
  logic [PW-1:0]    w_ptr_inc;
  logic [PW-1:0]    w_ptr_dec;
  logic             w_do_pop;

  // r_ptr is the next free slot; when full it also addresses the oldest entry,
  // which is exactly the one a wrapping push must overwrite.
  assign w_ptr_inc = (r_ptr == LAST_IDX) ? '0 : r_ptr + PW'(1);
  assign w_ptr_dec = (r_ptr == '0) ? LAST_IDX : r_ptr - PW'(1);

  assign full     = (r_count == CW'(DEPTH));
  assign empty    = (r_count == '0);
  assign count    = r_count;
  assign top      = r_mem[w_ptr_dec];
  assign w_do_pop = pop && !push && !empty;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ptr   <= '0;
      r_count <= '0;
    end else if (push) begin
      r_ptr <= w_ptr_inc;
      if (!full) r_count <= r_count + CW'(1);
    end else if (w_do_pop) begin
      r_ptr   <= w_ptr_dec;
      r_count <= r_count - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push) r_mem[r_ptr] <= push_data;
  end

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: registered PC with advance, relative branch,
// absolute jump and call/return through a circular return-address stack.
module pc_sequencer
  import pc_pkg::*;
#(
  parameter int               WIDTH      = 16,
  parameter logic [WIDTH-1:0] RESET_ADDR = '0,
  parameter int               RAS_DEPTH  = 8
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic                           stall,
  input  logic                           controle,
  input  logic                           hab_jump,
  input  logic [WIDTH-1:0]               jump_pc,
  input  logic                           branch_en,
  input  logic [WIDTH-1:0]               branch_off,
  input  logic                           call_en,
  input  logic                           ret_en,
  output logic [WIDTH-1:0]               pc_out,
  output logic [$clog2(RAS_DEPTH+1)-1:0] ras_count,
  output logic                           ras_overflow,
  output logic                           ras_underflow
);

  pc_op_t           w_op;
  logic [WIDTH-1:0] w_next_pc;
  logic [WIDTH-1:0] w_pc_inc;
  logic [WIDTH-1:0] w_ras_top;
  logic             w_ras_full;
  logic             w_ras_empty;
  logic             w_push;
  logic             w_pop;
  logic [WIDTH-1:0] r_pc;
  logic             r_overflow;
  logic             r_underflow;

  assign w_op     = stall ? PC_HOLD
                          : pc_decode(ret_en, call_en, hab_jump, branch_en, controle);
  assign w_pc_inc = r_pc + WIDTH'(1);
  assign w_push   = (w_op == PC_CALL);
  assign w_pop    = (w_op == PC_RET);

  pc_ras #(
    .WIDTH (WIDTH),
    .DEPTH (RAS_DEPTH)
  ) u_ras (
    .clk       (clock),
    .rst       (reset),
    .push      (w_push),
    .pop       (w_pop),
    .push_data (w_pc_inc),
    .top       (w_ras_top),
    .count     (ras_count),
    .full      (w_ras_full),
    .empty     (w_ras_empty)
  );

  always_comb begin
    w_next_pc = r_pc;
    unique case (w_op)
      PC_INC:    w_next_pc = w_pc_inc;
      PC_BRANCH: w_next_pc = r_pc + branch_off;
      PC_JUMP:   w_next_pc = jump_pc;
      PC_CALL:   w_next_pc = jump_pc;
      PC_RET:    if (!w_ras_empty) w_next_pc = w_ras_top;
      default:   w_next_pc = r_pc;
    endcase
  end

  // Flags are single-cycle pulses recomputed every edge, so they never stick.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_pc        <= RESET_ADDR;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      r_pc        <= w_next_pc;
      r_overflow  <= (w_op == PC_CALL) && w_ras_full;
      r_underflow <= (w_op == PC_RET) && w_ras_empty;
    end
  end

  assign pc_out        = r_pc;
  assign ras_overflow  = r_overflow;
  assign ras_underflow = r_underflow;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: linear command sequence with immediate
// assertions; a small return-stack model supplies call/return expectations.
module tb_pc_sequencer;

  logic        clock;
  logic        reset;
  logic        stall;
  logic        controle;
  logic        hab_jump;
  logic [15:0] jump_pc;
  logic        branch_en;
  logic [15:0] branch_off;
  logic        call_en;
  logic        ret_en;
  logic [15:0] pc_out;
  logic [3:0]  ras_count;
  logic        ras_overflow;
  logic        ras_underflow;
  logic [15:0] pc_out_b;
  logic [3:0]  ras_count_b;
  logic        ras_overflow_b;
  logic        ras_underflow_b;

  int          n_checks;
  int          n_errors;
  logic [15:0] exp_pc;
  logic [15:0] exp_q[$];

  pc_sequencer #(.WIDTH(16), .RESET_ADDR(16'h0000), .RAS_DEPTH(8)) dut (
    .clock(clock), .reset(reset), .stall(stall), .controle(controle),
    .hab_jump(hab_jump), .jump_pc(jump_pc), .branch_en(branch_en),
    .branch_off(branch_off), .call_en(call_en), .ret_en(ret_en),
    .pc_out(pc_out), .ras_count(ras_count), .ras_overflow(ras_overflow),
    .ras_underflow(ras_underflow)
  );

  pc_sequencer #(.WIDTH(16), .RESET_ADDR(16'h0100), .RAS_DEPTH(8)) dut_b (
    .clock(clock), .reset(reset), .stall(stall), .controle(controle),
    .hab_jump(hab_jump), .jump_pc(jump_pc), .branch_en(branch_en),
    .branch_off(branch_off), .call_en(call_en), .ret_en(ret_en),
    .pc_out(pc_out_b), .ras_count(ras_count_b), .ras_overflow(ras_overflow_b),
    .ras_underflow(ras_underflow_b)
  );

  // clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic clear_cmds();
    stall      = 1'b0;
    controle   = 1'b0;
    hab_jump   = 1'b0;
    jump_pc    = 16'h0000;
    branch_en  = 1'b0;
    branch_off = 16'h0000;
    call_en    = 1'b0;
    ret_en     = 1'b0;
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // driver tasks
  task automatic do_jump(input logic [15:0] target);
    hab_jump = 1'b1;
    jump_pc  = target;
    tick();
    clear_cmds();
    exp_pc = target;
    check("jump_pc", pc_out, exp_pc);
  endtask

  task automatic do_call(input string tag, input logic [15:0] target);
    logic exp_ovf;
    exp_ovf = (exp_q.size() == 8);
    exp_q.push_back(exp_pc + 16'h0001);
    if (exp_ovf) void'(exp_q.pop_front());
    call_en = 1'b1;
    jump_pc = target;
    tick();
    clear_cmds();
    exp_pc = target;
    check({tag, "_pc"}, pc_out, exp_pc);
    check({tag, "_cnt"}, ras_count, exp_q.size());
    check({tag, "_ovf"}, ras_overflow, exp_ovf);
  endtask

  task automatic do_ret(input string tag);
    logic exp_unf;
    exp_unf = (exp_q.size() == 0);
    if (!exp_unf) exp_pc = exp_q.pop_back();
    ret_en = 1'b1;
    tick();
    clear_cmds();
    check({tag, "_pc"}, pc_out, exp_pc);
    check({tag, "_cnt"}, ras_count, exp_q.size());
    check({tag, "_unf"}, ras_underflow, exp_unf);
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    clear_cmds();
    reset = 1'b1;
    exp_pc = 16'h0000;

    // Reset state, both reset vectors
    repeat (2) tick();
    check("rst_pc", pc_out, 16'h0000);
    check("rst_cnt", ras_count, 4'd0);
    check("rst_ovf", ras_overflow, 1'b0);
    check("rst_unf", ras_underflow, 1'b0);
    check("rst_pc_b", pc_out_b, 16'h0100);

    // First edge after release executes the pending command
    reset    = 1'b0;
    controle = 1'b1;
    check("rel_pc", pc_out, 16'h0000);
    tick(); check("inc1", pc_out, 16'h0001);
    check("inc1_b", pc_out_b, 16'h0101);
    tick(); check("inc2", pc_out, 16'h0002);
    tick(); check("inc3", pc_out, 16'h0003);
    clear_cmds();
    tick(); check("hold", pc_out, 16'h0003);

    // Wrap and branch
    do_jump(16'hFFFF);
    controle = 1'b1;
    tick(); clear_cmds();
    check("wrap", pc_out, 16'h0000);
    do_jump(16'h0010);
    branch_en  = 1'b1;
    branch_off = 16'hFFFC;
    tick(); clear_cmds();
    check("branch_neg", pc_out, 16'h000C);
    branch_en  = 1'b1;
    branch_off = 16'h0007;
    tick(); clear_cmds();
    check("branch_pos", pc_out, 16'h0013);

    // Jump beats branch and advance
    controle   = 1'b1;
    hab_jump   = 1'b1;
    jump_pc    = 16'h0040;
    branch_en  = 1'b1;
    branch_off = 16'h0005;
    tick(); clear_cmds();
    check("prio_jump", pc_out, 16'h0040);
    exp_pc = 16'h0040;

    // Nested calls
    do_jump(16'h0005);
    do_call("call1", 16'h0100);
    check("call1_cnt_lit", ras_count, 4'd1);
    controle = 1'b1;
    repeat (2) tick();
    clear_cmds();
    exp_pc = 16'h0102;
    check("adv_in_callee", pc_out, 16'h0102);
    do_call("call2", 16'h0200);
    check("call2_cnt_lit", ras_count, 4'd2);
    do_ret("ret1");
    check("ret1_lit", pc_out, 16'h0103);
    check("ret1_cnt_lit", ras_count, 4'd1);
    do_ret("ret2");
    check("ret2_lit", pc_out, 16'h0006);
    check("ret2_cnt_lit", ras_count, 4'd0);

    // Return beats call: pop only
    do_call("call3", 16'h0300);
    ret_en  = 1'b1;
    call_en = 1'b1;
    jump_pc = 16'h0400;
    tick(); clear_cmds();
    exp_pc = exp_q.pop_back();
    check("prio_ret_pc", pc_out, 16'h0007);
    check("prio_ret_cnt", ras_count, 4'd0);

    // Stall overrides everything
    do_call("call4", 16'h0500);
    stall = 1'b1; controle = 1'b1; hab_jump = 1'b1; jump_pc = 16'h0777;
    branch_en = 1'b1; branch_off = 16'h0003; call_en = 1'b1; ret_en = 1'b1;
    tick(); tick(); clear_cmds();
    check("stall_pc", pc_out, 16'h0500);
    check("stall_cnt", ras_count, 4'd1);
    check("stall_ovf", ras_overflow, 1'b0);
    check("stall_unf", ras_underflow, 1'b0);
    do_ret("ret_after_stall");
    check("ret_after_stall_lit", pc_out, 16'h0008);

    // Call immediately followed by return
    do_call("b2b_call", 16'h0600);
    do_ret("b2b_ret");
    check("b2b_ret_lit", pc_out, 16'h0009);

    // Overflow: nine calls, oldest address lost
    do_jump(16'h1000);
    for (int i = 0; i < 9; i++) begin
      do_call("ovf_call", 16'h1000 + 16'(16 * (i + 1)));
    end
    check("ovf_cnt_lit", ras_count, 4'd8);
    check("ovf_pulse_lit", ras_overflow, 1'b1);
    tick();
    check("ovf_not_sticky", ras_overflow, 1'b0);
    for (int i = 0; i < 8; i++) begin
      do_ret("ovf_ret");
    end
    check("ovf_last_ret_lit", pc_out, 16'h1011);
    do_ret("unf_ret");
    check("unf_pc_lit", pc_out, 16'h1011);
    check("unf_pulse_lit", ras_underflow, 1'b1);
    tick();
    check("unf_not_sticky", ras_underflow, 1'b0);

    // Asynchronous reset between edges
    do_call("pre_rst_call1", 16'h2000);
    do_call("pre_rst_call2", 16'h3000);
    #3;
    reset = 1'b1;
    #1;
    check("async_rst_pc", pc_out, 16'h0000);
    check("async_rst_cnt", ras_count, 4'd0);
    check("async_rst_pc_b", pc_out_b, 16'h0100);
    tick();
    reset = 1'b0;
    exp_q.delete();
    exp_pc = 16'h0000;
    do_ret("post_rst_ret");
    check("post_rst_unf_lit", ras_underflow, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
